fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8: instruction-memory address width.
REQ-002 Parameter DATA_W, default 16: instruction width, matching the core instruction bus.
REQ-003 Parameter TIMEOUT_CYC, default 64: maximum cycles to wait for core done before aborting.
REQ-004 Port clk, input, 1: single clock, all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port start, input, 1: one-cycle request to run a program from address 0.
REQ-007 Port prog_len, input, ADDR_W: number of instructions to execute, sampled when start is accepted.
REQ-008 Port mem_rd_en, output, 1: instruction-memory read strobe.
REQ-009 Port mem_addr, output, ADDR_W: instruction-memory read address.
REQ-010 Port mem_data, input, DATA_W: memory read data, valid exactly one cycle after mem_rd_en.
REQ-011 Port run, output, 1: one-cycle pulse telling the core to execute instruction.
REQ-012 Port instruction, output, DATA_W: registered instruction presented to the core.
REQ-013 Port done, input, 1: core completion pulse.
REQ-014 Port busy, output, 1: high in every state except IDLE.
REQ-015 Port pc, output, ADDR_W: current program counter.
REQ-016 Port finished, output, 1: one-cycle pulse on normal program completion.
REQ-017 Port timeout_err, output, 1: sticky flag, set when core done is not seen within TIMEOUT_CYC.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, MEMWAIT, ISSUE, EXEC.
REQ-019 IDLE SHALL behave as follows: start=1 and prog_len!=0 -> pc<=0, latch prog_len, clear timeout_err, go to FETCH; start=1 and prog_len==0 -> pulse finished next cycle and stay IDLE.
REQ-020 FETCH SHALL assert mem_rd_en=1 with mem_addr=pc for exactly one cycle, then go to MEMWAIT.
REQ-021 MEMWAIT SHALL capture mem_data into the instruction register, then go to ISSUE.
REQ-022 ISSUE SHALL assert run=1 for exactly one cycle, clear the timeout counter, then go to EXEC.
REQ-023 instruction SHALL be stable from capture until the next capture; the core sees a valid instruction in the same cycle as run.
REQ-024 In EXEC, done=1 and pc==latched_len-1 SHALL pulse finished and return to IDLE with pc unchanged.
REQ-025 In EXEC, done=1 otherwise SHALL set pc<=pc+1 and go to FETCH.
REQ-026 In EXEC, the counter SHALL increment each cycle without done; reaching TIMEOUT_CYC SHALL set timeout_err, leave finished low, and return to IDLE.
REQ-027 done SHALL be ignored in every state except EXEC.
REQ-028 start SHALL be ignored while busy=1.
REQ-029 Programs SHALL be limited to 255 instructions (prog_len=255 is the maximum); pc never wraps within a program.
REQ-030 Per-instruction latency with done returning k cycles after run SHALL be 3+k cycles (FETCH, MEMWAIT, ISSUE, plus k cycles in EXEC).
REQ-031 mem_rd_en, run and finished SHALL be low outside the states specified above.

Reset
REQ-032 reset=1 SHALL force IDLE, pc=0, instruction=0, latched length=0, timeout counter=0, run=0, mem_rd_en=0, mem_addr=0, busy=0, finished=0, timeout_err=0.
REQ-033 reset asserted mid-program SHALL abort on the next edge with no run or finished pulse.
REQ-034 reset SHALL take priority over start and done in the same cycle.

Structure
REQ-035 A shared package fetch_pkg SHALL hold the state enum, ADDR_W/DATA_W defaults and the TIMEOUT_CYC default.
REQ-036 The PC, with load-zero and increment, SHALL be one sub-module, pc_counter; the FSM and datapath SHALL stay in fetch_unit.

Verification
REQ-037 Scenario 1: prog_len=3, mem={0x1111,0x2222,0x3333}, done 2 cycles after each run -> three run pulses carrying those instructions in order, finished pulse, pc=2, busy low.
REQ-038 Scenario 2: start with prog_len=0 -> no mem_rd_en and no run; finished pulse one cycle later.
REQ-039 Scenario 3: done never returns after the first run -> timeout_err=1 after 64 EXEC cycles, IDLE, finished=0.
REQ-040 Scenario 4: start repulsed mid-program and done pulsed during ISSUE/FETCH -> both ignored; sequence and pc unchanged.
REQ-041 Scenario 5: reset asserted in EXEC of instruction 2 of 5 -> all outputs zero next cycle; a new start then runs from pc=0.
REQ-042 Scenario 6: prog_len=255 with done returned in the first EXEC cycle -> 255 runs at 4-cycle spacing, final pc=254, finished pulse.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared state encoding and default sizes for the fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================

package fetch_pkg;

    localparam int c_addr_w_default      = 8;
    localparam int c_data_w_default      = 16;
    localparam int c_timeout_cyc_default = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_MEMWAIT = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_EXEC    = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pc_counter.sv
`default_nettype none
// ============================================================================
// Module      : pc_counter
// Description : Program counter with synchronous clear-to-zero and increment.
// Revision    : 1.0 - initial release
// ============================================================================

module pc_counter
    import fetch_pkg::*;
#(
    parameter int WIDTH = c_addr_w_default
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Clear wins over increment so a program restart always begins at 0.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Sequences instruction fetch from memory and hands each word to
//               the core, waiting (with timeout) for its done pulse.
// Revision    : 1.0 - initial release
// ============================================================================

module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W      = c_addr_w_default,
    parameter int DATA_W      = c_data_w_default,
    parameter int TIMEOUT_CYC = c_timeout_cyc_default
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] prog_len,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              run,
    output logic [DATA_W-1:0] instruction,
    input  logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] pc,
    output logic              finished,
    output logic              timeout_err
);

    localparam int                c_tmo_w     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_limit = c_tmo_w'(TIMEOUT_CYC);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_len;
    logic [c_tmo_w-1:0]  r_tmo_cnt;
    logic                r_mem_rd_en;
    logic                r_run;
    logic                r_finished;
    logic                r_timeout_err;
    logic [DATA_W-1:0]   r_instruction;

    logic                w_accept;
    logic                w_last;
    logic                w_pc_inc;
    logic [c_tmo_w-1:0]  w_tmo_next;
    logic                w_tmo_hit;
    logic [ADDR_W-1:0]   w_pc;

    assign w_accept   = (r_state == ST_IDLE) && start && (prog_len != '0);
    assign w_last     = (w_pc == r_len - 1'b1);
    assign w_pc_inc   = (r_state == ST_EXEC) && done && !w_last;
    assign w_tmo_next = r_tmo_cnt + 1'b1;
    assign w_tmo_hit  = (w_tmo_next == c_tmo_limit);

    pc_counter #(
        .WIDTH (ADDR_W)
    ) u_pc (
        .clk     (clk),
        .rst     (reset),
        .i_clr   (w_accept),
        .i_inc   (w_pc_inc),
        .o_count (w_pc)
    );

    // Outputs are registered on entry to the state that owns them, so each
    // strobe is high for exactly the one cycle spent in that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_len         <= '0;
            r_tmo_cnt     <= '0;
            r_mem_rd_en   <= 1'b0;
            r_run         <= 1'b0;
            r_finished    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_instruction <= '0;
        end else begin
            r_mem_rd_en <= 1'b0;
            r_run       <= 1'b0;
            r_finished  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (prog_len != '0) begin
                            r_len         <= prog_len;
                            r_timeout_err <= 1'b0;
                            r_mem_rd_en   <= 1'b1;
                            r_state       <= ST_FETCH;
                        end else begin
                            r_finished <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_MEMWAIT;
                end
                ST_MEMWAIT: begin
                    r_instruction <= mem_data;
                    r_run         <= 1'b1;
                    r_state       <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    r_tmo_cnt <= '0;
                    r_state   <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (done) begin
                        if (w_last) begin
                            r_finished <= 1'b1;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_mem_rd_en <= 1'b1;
                            r_state     <= ST_FETCH;
                        end
                    end else if (w_tmo_hit) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_tmo_cnt <= w_tmo_next;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_rd_en   = r_mem_rd_en;
    assign mem_addr    = w_pc;
    assign run         = r_run;
    assign instruction = r_instruction;
    assign busy        = (r_state != ST_IDLE);
    assign pc          = w_pc;
    assign finished    = r_finished;
    assign timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench: memory/core models, instruction scoreboard
//               and a table of whole-program vectors plus reset corner case.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_fetch_unit;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  prog_len;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [15:0] mem_data;
    logic        run;
    logic [15:0] instruction;
    logic        done;
    logic        busy;
    logic [7:0]  pc;
    logic        finished;
    logic        timeout_err;

    fetch_unit #(
        .ADDR_W      (8),
        .DATA_W      (16),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .prog_len    (prog_len),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .run         (run),
        .instruction (instruction),
        .done        (done),
        .busy        (busy),
        .pc          (pc),
        .finished    (finished),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int k;
        bit inj;
        int exp_runs;
        int exp_pc;
        bit exp_fin;
        bit exp_tmo;
    } vec_t;

    logic [15:0] mem [256];
    logic [15:0] sb_q [$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int run_cnt, rd_cnt, fin_cnt, last_run_cyc, done_cnt, cfg_k;
    bit cfg_inj, rd_prev;
    logic [7:0] rd_addr_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: observe outputs at the falling edge, then drive memory/core inputs.
    task automatic tick();
        @(negedge clk);
        cyc++;
        start    = 1'b0;
        done     = 1'b0;
        mem_data = 16'hDEAD;
        if (rd_prev) mem_data = mem[rd_addr_prev];
        rd_prev = mem_rd_en;
        if (mem_rd_en) begin
            check("rd_addr", {24'd0, mem_addr}, rd_cnt);
            sb_q.push_back(mem[mem_addr]);
            rd_addr_prev = mem_addr;
            rd_cnt++;
            if (cfg_inj) begin
                start    = 1'b1;
                prog_len = 8'd7;
                done     = 1'b1;
            end
        end
        if (finished) fin_cnt++;
        if (run) begin
            if (sb_q.size() == 0) check("sb_underflow", 1, 0);
            else check("instr", {16'd0, instruction}, {16'd0, sb_q.pop_front()});
            if (run_cnt > 0 && cfg_k > 0) check("run_gap", cyc - last_run_cyc, cfg_k + 3);
            last_run_cyc = cyc;
            run_cnt++;
            done_cnt = (cfg_k > 0) ? cfg_k : -1;
            if (cfg_inj) done = 1'b1;
        end else if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) begin
                done     = 1'b1;
                done_cnt = -1;
            end
        end
    endtask

    task automatic prep(input int len, input int k, input bit inj);
        run_cnt  = 0;
        rd_cnt   = 0;
        fin_cnt  = 0;
        done_cnt = -1;
        rd_prev  = 1'b0;
        cfg_k    = k;
        cfg_inj  = inj;
        sb_q.delete();
        start    = 1'b1;
        prog_len = 8'(len);
    endtask

    task automatic run_prog(input int len, input int k, input bit inj,
                            output int steps, output int tmo_delta);
        steps     = 0;
        tmo_delta = -1;
        prep(len, k, inj);
        while (steps < 3000) begin
            tick();
            steps++;
            if (finished) break;
            if (timeout_err && !busy) begin
                tmo_delta = cyc - last_run_cyc;
                break;
            end
        end
        if (steps >= 3000) check("cycle_budget", 0, 1);
        cfg_inj = 1'b0;
        repeat (3) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_run"},   {31'd0, run},          0);
        check({tag, "_rd_en"}, {31'd0, mem_rd_en},    0);
        check({tag, "_addr"},  {24'd0, mem_addr},     0);
        check({tag, "_busy"},  {31'd0, busy},         0);
        check({tag, "_fin"},   {31'd0, finished},     0);
        check({tag, "_tmo"},   {31'd0, timeout_err},  0);
        check({tag, "_pc"},    {24'd0, pc},           0);
        check({tag, "_instr"}, {16'd0, instruction},  0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs [6];
        int steps, tmo_delta, n;

        for (int i = 0; i < 256; i++) mem[i] = 16'((i * 16'h0137) ^ 16'hA5A5);
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        mem[2] = 16'h3333;

        // len, k, inject, runs, final pc, finished, timeout
        vecs[0] = '{3,   2, 1'b0, 3,   2,   1'b1, 1'b0};
        vecs[1] = '{0,   2, 1'b0, 0,   2,   1'b1, 1'b0};
        vecs[2] = '{4,   0, 1'b0, 1,   0,   1'b0, 1'b1};
        vecs[3] = '{3,   2, 1'b1, 3,   2,   1'b1, 1'b0};
        vecs[4] = '{1,   5, 1'b0, 1,   0,   1'b1, 1'b0};
        vecs[5] = '{255, 1, 1'b0, 255, 254, 1'b1, 1'b0};

        reset    = 1'b1;
        start    = 1'b0;
        done     = 1'b0;
        prog_len = 8'd0;
        mem_data = 16'd0;
        done_cnt = -1;
        rd_prev  = 1'b0;
        cfg_inj  = 1'b0;
        cfg_k    = 0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            run_prog(vecs[v].len, vecs[v].k, vecs[v].inj, steps, tmo_delta);
            check($sformatf("v%0d_runs", v),   run_cnt, vecs[v].exp_runs);
            check($sformatf("v%0d_reads", v),  rd_cnt,  vecs[v].exp_runs);
            check($sformatf("v%0d_fin", v),    fin_cnt, {31'd0, vecs[v].exp_fin});
            check($sformatf("v%0d_tmo", v),    {31'd0, timeout_err}, {31'd0, vecs[v].exp_tmo});
            check($sformatf("v%0d_pc", v),     {24'd0, pc}, vecs[v].exp_pc);
            check($sformatf("v%0d_busy", v),   {31'd0, busy}, 0);
            check($sformatf("v%0d_sb", v),     sb_q.size(), 0);
            if (vecs[v].exp_tmo) check($sformatf("v%0d_tmo_lat", v), tmo_delta, TMO + 1);
            if (vecs[v].len == 0) check($sformatf("v%0d_fin_lat", v), steps, 1);
        end

        // Reset in EXEC of the second instruction, with start and done also high.
        prep(5, 3, 1'b0);
        n = 0;
        while (run_cnt < 2 && n < 100) begin
            tick();
            n++;
        end
        check("rst_reach_run2", run_cnt, 2);
        tick();
        reset = 1'b1;
        start = 1'b1;
        prog_len = 8'd9;
        done  = 1'b1;
        @(negedge clk);
        cyc++;
        check_all_zero("midrst");
        reset = 1'b0;
        start = 1'b0;
        done  = 1'b0;
        fin_cnt = 0;
        run_cnt = 0;
        done_cnt = -1;
        rd_prev = 1'b0;
        repeat (3) tick();
        check("midrst_no_run", run_cnt, 0);
        check("midrst_no_fin", fin_cnt, 0);

        run_prog(2, 1, 1'b0, steps, tmo_delta);
        check("post_rst_runs", run_cnt, 2);
        check("post_rst_fin",  fin_cnt, 1);
        check("post_rst_pc",   {24'd0, pc}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
